// File: rtl/arbiter8_rr_if.sv
// Bundle of the requester/resource handshake signals around arbiter8_rr.
// The slave modport is the arbiter's view. The master modport is the
// requester/resource side that drives req and res_resp.
interface arbiter8_rr_if;
  logic [7:0] req;
  logic       res_resp;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       res_start;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req,
    output res_resp,
    input  sel,
    input  gnt,
    input  res_start,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  res_resp,
    output sel,
    output gnt,
    output res_start,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/arbiter8_rr.sv
// Round-robin arbiter/sequencer that shares one single-transaction resource
// among 8 requesters.
// A grant issues a one-cycle res_start. The grant is then held until
// res_resp arrives or the optional timeout forces a release.
// The requester that was served last gets the lowest priority in the next round.
module arbiter8_rr #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  arbiter8_rr_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // First set request bit, scanning upward from ptr with wrap-around.
  function automatic logic [2:0] rr_pick(input logic [7:0] req_v, input logic [2:0] ptr_v);
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    win   = ptr_v;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_v + 3'(i);
      if (req_v[idx] && !found) begin
        win   = idx;
        found = 1'b1;
      end else begin
        win   = win;
        found = found;
      end
    end
    return win;
  endfunction

  // One-hot encoding of a 3-bit requester index.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    logic [7:0] oh;
    oh      = 8'h00;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       sel_r, sel_s;
  logic [7:0]       gnt_r, gnt_s;
  logic             res_start_r, res_start_s;
  logic             busy_r, busy_s;
  logic             timeout_err_r, timeout_err_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       win_s;

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT sequencer.
  always_comb begin
    state_s       = state_r;
    sel_s         = sel_r;
    gnt_s         = gnt_r;
    res_start_s   = 1'b0;
    timeout_err_s = 1'b0;
    ptr_s         = ptr_r;
    cnt_s         = cnt_r;
    win_s         = rr_pick(bus.req, ptr_r);

    case (state_r)
      ST_IDLE: begin
        // sel keeps its last value here so that the datapath mux stays stable.
        if (bus.req != 8'h00) begin
          sel_s       = win_s;
          gnt_s       = onehot8(win_s);
          res_start_s = 1'b1;
          state_s     = ST_ISSUE;
        end else begin
          gnt_s   = 8'h00;
          state_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        cnt_s = CNT_ZERO;
        // A response that arrives in the start cycle still counts as completion.
        if (bus.res_resp) begin
          gnt_s   = 8'h00;
          ptr_s   = sel_r + 3'd1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.res_resp) begin
          // Completion takes precedence over a timeout in the same cycle.
          gnt_s   = 8'h00;
          ptr_s   = sel_r + 3'd1;
          state_s = ST_IDLE;
        end else if (TMO_EN && (cnt_r == CNT_LAST)) begin
          gnt_s         = 8'h00;
          ptr_s         = sel_r + 3'd1;
          timeout_err_s = 1'b1;
          state_s       = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
          // The counter saturates so that it can never wrap back to a match.
          if (cnt_r == CNT_MAX) begin
            cnt_s = cnt_r;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
      end

      default: begin
        // Any illegal encoding returns the sequencer to a safe idle state.
        state_s = ST_IDLE;
        gnt_s   = 8'h00;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers. A synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      sel_r         <= 3'd0;
      gnt_r         <= 8'h00;
      res_start_r   <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      ptr_r         <= 3'd0;
      cnt_r         <= CNT_ZERO;
    end else begin
      state_r       <= state_s;
      sel_r         <= sel_s;
      gnt_r         <= gnt_s;
      res_start_r   <= res_start_s;
      busy_r        <= busy_s;
      timeout_err_r <= timeout_err_s;
      ptr_r         <= ptr_s;
      cnt_r         <= cnt_s;
    end
  end

  assign bus.sel         = sel_r;
  assign bus.gnt         = gnt_r;
  assign bus.res_start   = res_start_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;

endmodule
